// File: rtl/draw_pkg.sv
// Shared definitions for the draw-command path: opcodes, dispatcher states and default widths.
package draw_pkg;

    localparam logic [3:0] OP_SPIXEL  = 4'h0;
    localparam logic [3:0] OP_RECT_SP = 4'h1;
    localparam logic [3:0] OP_RECT_PX = 4'h9;
    localparam logic [3:0] OP_CHAR    = 4'ha;

    localparam int unsigned H_PHY_WIDTH   = 10;
    localparam int unsigned V_PHY_WIDTH   = 9;
    localparam int unsigned H_LOGIC_WIDTH = 5;
    localparam int unsigned V_LOGIC_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        DISPATCH = 2'd2,
        BUSY     = 2'd3
    } state_t;

endpackage

// File: rtl/ram_wr_arbiter.sv
// Registered lowest-index-wins mux of N engine RAM write ports onto one RAM port.
module ram_wr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned AW = 19,
    parameter int unsigned DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N*AW-1:0] i_addr,
    input  logic [N*DW-1:0] i_data,
    input  logic [N-1:0]  i_wren,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_data,
    output logic          o_wren
);

    logic          r_wren;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          w_any;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;

    // Descending scan so the lowest active index is the last to assign.
    always_comb begin
        w_any  = 1'b0;
        w_addr = r_addr;
        w_data = r_data;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (i_wren[i]) begin
                w_any  = 1'b1;
                w_addr = i_addr[i*AW +: AW];
                w_data = i_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wren <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_wren <= w_any;
            r_addr <= w_addr;
            r_data <= w_data;
        end
    end

    assign o_wren = r_wren;
    assign o_addr = r_addr;
    assign o_data = r_data;

endmodule

// File: rtl/draw_cmd_dispatcher.sv
// Pops draw commands, starts the engine owning the opcode and muxes engine RAM writes.
// Define DRAW_DISPATCH_TIMEOUT_EN to add a BUSY watchdog of TIMEOUT_CYCLES cycles.
module draw_cmd_dispatcher
    import draw_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned OP_WIDTH       = 4,
    parameter int unsigned N_ENG          = 4,
    parameter logic [N_ENG*OP_WIDTH-1:0] OP_TABLE = {OP_CHAR, OP_RECT_PX, OP_RECT_SP, OP_SPIXEL},
    parameter logic [N_ENG-1:0] HALF_MASK = 4'b1100,
    parameter int unsigned ADDR_WIDTH     = 19,
    parameter int unsigned COLOR_ID_WIDTH = 8,
    parameter int unsigned ERR_WIDTH      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_enb,
    input  logic                          i_ff_empty,
    output logic                          o_ff_rden,
    input  logic [DATA_WIDTH-1:0]         i_ff_rdat,
    input  logic                          i_ff_rvld,
    output logic [DATA_WIDTH-1:0]         o_eng_cmd,
    output logic [N_ENG-1:0]              o_eng_vld,
    input  logic [N_ENG-1:0]              i_eng_done,
    input  logic [N_ENG*ADDR_WIDTH-1:0]   i_eng_addr,
    input  logic [N_ENG*COLOR_ID_WIDTH-1:0] i_eng_data,
    input  logic [N_ENG-1:0]              i_eng_wren,
    output logic [ADDR_WIDTH-1:0]         o_ram_addr,
    output logic [COLOR_ID_WIDTH-1:0]     o_ram_data,
    output logic                          o_ram_wren,
    output logic                          o_busy,
    output logic [ERR_WIDTH-1:0]          o_err_cnt
);

    localparam int unsigned OWN_W = (N_ENG > 1) ? $clog2(N_ENG) : 1;

    state_t                r_state, w_state_nxt;
    logic [OWN_W-1:0]      r_owner, w_owner_nxt;
    logic [DATA_WIDTH-1:0] r_cmd, w_cmd_nxt;
    logic [ERR_WIDTH-1:0]  r_err, w_err_nxt, w_err_inc;
    logic [N_ENG-1:0]      r_vld, w_vld_nxt;
    logic                  r_busy;
    logic                  w_hit;
    logic [OWN_W-1:0]      w_hit_idx;
    logic [OP_WIDTH-1:0]   w_op;
    logic                  w_rden;

    assign w_op      = i_ff_rdat[DATA_WIDTH-1 -: OP_WIDTH];
    assign w_err_inc = (&r_err) ? r_err : r_err + ERR_WIDTH'(1);

    // Lowest matching table slice owns the command.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = int'(N_ENG) - 1; i >= 0; i--) begin
            if (OP_TABLE[i*OP_WIDTH +: OP_WIDTH] == w_op) begin
                w_hit     = 1'b1;
                w_hit_idx = OWN_W'(i);
            end
        end
    end

`ifdef DRAW_DISPATCH_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo;
    logic             w_tmo_hit;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_tmo <= '0;
        end else if (r_state != BUSY) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + TMO_W'(1);
        end
    end

    assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cmd_nxt   = r_cmd;
        w_err_nxt   = r_err;
        w_rden      = 1'b0;
        w_vld_nxt   = '0;
        case (r_state)
            IDLE: begin
                w_rden = i_enb & ~i_ff_empty;
                if (w_rden) w_state_nxt = FETCH;
            end
            FETCH: begin
                if (i_ff_rvld) begin
                    w_cmd_nxt = i_ff_rdat;
                    if (w_hit) begin
                        w_owner_nxt = w_hit_idx;
                        w_state_nxt = DISPATCH;
                    end else begin
                        w_err_nxt   = w_err_inc;
                        w_state_nxt = IDLE;
                    end
                end
            end
            DISPATCH: begin
                if ((HALF_MASK[r_owner] & ~r_cmd[0]) | i_eng_done[r_owner]) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (i_eng_done[r_owner]) begin
                    w_state_nxt = IDLE;
                end
`ifdef DRAW_DISPATCH_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_err_nxt   = w_err_inc;
                    w_state_nxt = IDLE;
                end
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_state_nxt == DISPATCH) begin
            w_vld_nxt = N_ENG'(1) << w_owner_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_cmd   <= '0;
            r_err   <= '0;
            r_vld   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_cmd   <= w_cmd_nxt;
            r_err   <= w_err_nxt;
            r_vld   <= w_vld_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    ram_wr_arbiter #(
        .N  (N_ENG),
        .AW (ADDR_WIDTH),
        .DW (COLOR_ID_WIDTH)
    ) u_ram_arb (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_addr (i_eng_addr),
        .i_data (i_eng_data),
        .i_wren (i_eng_wren),
        .o_addr (o_ram_addr),
        .o_data (o_ram_data),
        .o_wren (o_ram_wren)
    );

    // Read strobe is held low while reset is asserted.
    assign o_ff_rden = w_rden & i_rst;
    assign o_eng_cmd = r_cmd;
    assign o_eng_vld = r_vld;
    assign o_busy    = r_busy;
    assign o_err_cnt = r_err;

endmodule
